// File: rtl/hex_display_scan_if.sv
// hex_display_scan_if: value/control inputs and display pins of the multiplexed hex display
interface hex_display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      i_enable;
    logic                      i_load;
    logic [4*NUM_DIGITS-1:0]   i_value;
    logic [NUM_DIGITS-1:0]     i_dp;
    logic [NUM_DIGITS-1:0]     i_blank;
    logic                      i_lzb;
    logic [6:0]                o_segment;
    logic                      o_dp;
    logic [NUM_DIGITS-1:0]     o_digit;

    modport master (
        output i_enable, i_load, i_value, i_dp, i_blank, i_lzb,
        input  o_segment, o_dp, o_digit
    );

    modport slave (
        input  i_enable, i_load, i_value, i_dp, i_blank, i_lzb,
        output o_segment, o_dp, o_digit
    );
endinterface

// File: rtl/hex_display_scan.sv
// hex_display_scan: time-multiplexed 7-segment hex driver with frame-synchronous value update
module hex_display_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int BLANK_CYCLES   = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input logic              i_clk,
    input logic              i_rst_n,
    hex_display_scan_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [111:0] SEG_LUT = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [VW-1:0]         sh_value, act_value;
    logic [NUM_DIGITS-1:0] sh_dp, sh_blank, act_dp, act_blank;
    logic                  pending;
    logic                  tc, frame_end, commit, dark, show;
    logic [3:0]            nib;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] sel;

    // Slot timing, commit point and the lit pattern of the currently selected digit
    always_comb begin
        tc        = cnt == CW'(REFRESH_DIV - 1);
        frame_end = tc && idx == IW'(NUM_DIGITS - 1);
        commit    = !bus.i_enable || frame_end;
        nib       = 4'(act_value >> {idx, 2'b00});
        dark      = act_blank[idx] || (bus.i_lzb && idx != '0 && (act_value >> {idx, 2'b00}) == '0);
        show      = bus.i_enable && cnt >= CW'(BLANK_CYCLES);
        seg       = show && !dark ? 7'(SEG_LUT >> (32'(nib) * 7)) : 7'h00;
        sel       = show ? NUM_DIGITS'(1) << idx : '0;
    end

    // Prescaler and digit index; both parked at 0 while scanning is disabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!bus.i_enable) begin
            cnt <= '0;
            idx <= '0;
        end else if (tc) begin
            cnt <= '0;
            idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow capture on load; active copy only changes at a frame end or while disabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_value  <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            act_value <= '0;
            act_dp    <= '0;
            act_blank <= '0;
            pending   <= 1'b0;
        end else begin
            if (bus.i_load) begin
                sh_value <= bus.i_value;
                sh_dp    <= bus.i_dp;
                sh_blank <= bus.i_blank;
            end
            if (commit) begin
                pending <= 1'b0;
                if (bus.i_load) begin
                    act_value <= bus.i_value;
                    act_dp    <= bus.i_dp;
                    act_blank <= bus.i_blank;
                end else if (pending) begin
                    act_value <= sh_value;
                    act_dp    <= sh_dp;
                    act_blank <= sh_blank;
                end
            end else if (bus.i_load) begin
                pending <= 1'b1;
            end
        end
    end

    // Registered pins at the configured polarities
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_segment <= {7{SEG_ACTIVE_LOW}};
            bus.o_dp      <= SEG_ACTIVE_LOW;
            bus.o_digit   <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
        end else begin
            bus.o_segment <= seg ^ {7{SEG_ACTIVE_LOW}};
            bus.o_dp      <= (show && !dark && act_dp[idx]) ^ SEG_ACTIVE_LOW;
            bus.o_digit   <= sel ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
        end
    end
endmodule
